// File: rtl/psr_unit.sv
// rtl/psr_unit.sv - processor status register stage downstream of the ALU
// Holds N,V,D,I,Z,C; merges ALU commits, flag ops, PLP, interrupt entry and the SO pin.
module psr_unit #(
   parameter int          SO_SYNC_STAGES = 2,
   parameter logic [7:0]  RESET_PSR      = 8'h34
) (
   input  logic       fclk,
   input  logic       resb,
   input  logic       psr_update_request,
   output logic       ack_update_request,
   input  logic       n_result,
   input  logic       v_result,
   input  logic       z_result,
   input  logic       c_result,
   input  logic [3:0] update_mask,
   input  logic       flag_op_valid,
   input  logic [2:0] flag_op,
   input  logic       plp_load,
   input  logic [7:0] db_in,
   input  logic       int_entry,
   input  logic       so_n,
   input  logic       push_is_irq,
   output logic [7:0] psr_to_id,
   output logic [7:0] psr_push_out,
   output logic       c_carry,
   output logic       d_decimal
);

   typedef enum logic {ST_IDLE, ST_ACK} state_t;

   state_t r_state, w_state_nxt;
   logic   w_commit;

   logic r_n, r_v, r_d, r_i, r_z, r_c;
   logic w_n, w_v, w_d, w_i, w_z, w_c;

   logic [SO_SYNC_STAGES-1:0] r_so_sync;
   logic                      r_so_last;
   logic                      w_so_fall;

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (psr_update_request) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!psr_update_request) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // r_so_last trails the last sync stage so a held-low pin fires only once
   assign w_so_fall = r_so_last & ~r_so_sync[SO_SYNC_STAGES-1];

   // Sources applied lowest priority first so later ones override per flag
   always_comb begin
      w_n = r_n;
      w_v = r_v;
      w_d = r_d;
      w_i = r_i;
      w_z = r_z;
      w_c = r_c;
      if (flag_op_valid) begin
         case (flag_op)
            3'd0: w_c = 1'b0;
            3'd1: w_c = 1'b1;
            3'd2: w_i = 1'b0;
            3'd3: w_i = 1'b1;
            3'd4: w_v = 1'b0;
            3'd5: w_d = 1'b0;
            3'd6: w_d = 1'b1;
            default: ;
         endcase
      end
      if (w_commit) begin
         if (update_mask[3]) w_n = n_result;
         if (update_mask[2]) w_v = v_result;
         if (update_mask[1]) w_z = z_result;
         if (update_mask[0]) w_c = c_result;
      end
      if (plp_load) begin
         w_n = db_in[7];
         w_v = db_in[6];
         w_d = db_in[3];
         w_i = db_in[2];
         w_z = db_in[1];
         w_c = db_in[0];
      end
      if (int_entry) begin
         w_i = 1'b1;
         w_d = 1'b0;
      end
      if (w_so_fall) w_v = 1'b1;
   end

   always_ff @(posedge fclk or negedge resb) begin
      if (!resb) begin
         r_state   <= ST_IDLE;
         r_so_sync <= '1;
         r_so_last <= 1'b1;
         r_n       <= RESET_PSR[7];
         r_v       <= RESET_PSR[6];
         r_d       <= RESET_PSR[3];
         r_i       <= RESET_PSR[2];
         r_z       <= RESET_PSR[1];
         r_c       <= RESET_PSR[0];
      end else begin
         r_state   <= w_state_nxt;
         r_so_sync <= {r_so_sync[SO_SYNC_STAGES-2:0], so_n};
         r_so_last <= r_so_sync[SO_SYNC_STAGES-1];
         r_n       <= w_n;
         r_v       <= w_v;
         r_d       <= w_d;
         r_i       <= w_i;
         r_z       <= w_z;
         r_c       <= w_c;
      end
   end

   assign ack_update_request = (r_state == ST_ACK);
   assign psr_to_id          = {r_n, r_v, 1'b1, 1'b1, r_d, r_i, r_z, r_c};
   assign psr_push_out       = {r_n, r_v, 1'b1, ~push_is_irq, r_d, r_i, r_z, r_c};
   assign c_carry            = r_c;
   assign d_decimal          = r_d;

endmodule

// File: tb/tb_psr_unit.sv
// tb/tb_psr_unit.sv - directed and random checks of psr_unit against a flag-level model
module tb_psr_unit;

   localparam int SYNC = 2;

   logic       fclk = 1'b0;
   logic       resb = 1'b0;
   logic       psr_update_request = 1'b0;
   logic       ack_update_request;
   logic       n_result = 1'b0, v_result = 1'b0, z_result = 1'b0, c_result = 1'b0;
   logic [3:0] update_mask = 4'd0;
   logic       flag_op_valid = 1'b0;
   logic [2:0] flag_op = 3'd7;
   logic       plp_load = 1'b0;
   logic [7:0] db_in = 8'd0;
   logic       int_entry = 1'b0;
   logic       so_n = 1'b1;
   logic       push_is_irq = 1'b0;
   logic [7:0] psr_to_id, psr_push_out;
   logic       c_carry, d_decimal;

   int total = 0;
   int bad   = 0;

   // Model state: architectural flags, ack level and the so_n value seen at recent edges
   logic m_n, m_v, m_d, m_i, m_z, m_c, m_ack;
   logic so_hist[$];

   psr_unit #(.SO_SYNC_STAGES(SYNC), .RESET_PSR(8'h34)) dut (
      .fclk(fclk), .resb(resb),
      .psr_update_request(psr_update_request), .ack_update_request(ack_update_request),
      .n_result(n_result), .v_result(v_result), .z_result(z_result), .c_result(c_result),
      .update_mask(update_mask), .flag_op_valid(flag_op_valid), .flag_op(flag_op),
      .plp_load(plp_load), .db_in(db_in), .int_entry(int_entry), .so_n(so_n),
      .push_is_irq(push_is_irq), .psr_to_id(psr_to_id), .psr_push_out(psr_push_out),
      .c_carry(c_carry), .d_decimal(d_decimal)
   );

   always #5 fclk = ~fclk;

   function automatic logic [7:0] m_psr();
      return {m_n, m_v, 2'b11, m_d, m_i, m_z, m_c};
   endfunction

   function automatic logic [7:0] m_push();
      return {m_n, m_v, 1'b1, ~push_is_irq, m_d, m_i, m_z, m_c};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic mdl_reset();
      {m_n, m_v, m_d, m_z, m_c} = 5'b0;
      m_i   = 1'b1;
      m_ack = 1'b0;
      so_hist.delete();
      for (int k = 0; k < SYNC + 2; k++) so_hist.push_back(1'b1);
   endtask

   // One clock edge of the architectural rules, lowest priority applied first
   task automatic mdl_edge();
      logic commit;
      logic so_set;
      commit = psr_update_request && !m_ack;
      so_hist.push_front(so_n);
      void'(so_hist.pop_back());
      so_set = (so_hist[SYNC] == 1'b0) && (so_hist[SYNC+1] == 1'b1);
      if (flag_op_valid) begin
         case (flag_op)
            3'd0: m_c = 1'b0;
            3'd1: m_c = 1'b1;
            3'd2: m_i = 1'b0;
            3'd3: m_i = 1'b1;
            3'd4: m_v = 1'b0;
            3'd5: m_d = 1'b0;
            3'd6: m_d = 1'b1;
            default: ;
         endcase
      end
      if (commit) begin
         if (update_mask[3]) m_n = n_result;
         if (update_mask[2]) m_v = v_result;
         if (update_mask[1]) m_z = z_result;
         if (update_mask[0]) m_c = c_result;
      end
      if (plp_load) {m_n, m_v, m_d, m_i, m_z, m_c} = {db_in[7:6], db_in[3:0]};
      if (int_entry) begin
         m_i = 1'b1;
         m_d = 1'b0;
      end
      if (so_set) m_v = 1'b1;
      m_ack = psr_update_request;
   endtask

   task automatic step(input string tag);
      @(posedge fclk);
      if (!resb) mdl_reset(); else mdl_edge();
      #1;
      chk({tag, ".psr"},  psr_to_id, m_psr());
      chk({tag, ".ack"},  {7'd0, ack_update_request}, {7'd0, m_ack});
      chk({tag, ".c"},    {7'd0, c_carry}, {7'd0, m_c});
      chk({tag, ".d"},    {7'd0, d_decimal}, {7'd0, m_d});
      chk({tag, ".push"}, psr_push_out, m_push());
   endtask

   task automatic clr_pulses();
      flag_op_valid = 1'b0;
      flag_op       = 3'd7;
      plp_load      = 1'b0;
      int_entry     = 1'b0;
   endtask

   task automatic fop(input logic [2:0] op);
      flag_op_valid = 1'b1;
      flag_op       = op;
   endtask

   initial begin
      mdl_reset();
      // Reset held for three cycles
      resb = 1'b0;
      for (int k = 0; k < 3; k++) step("rst");
      chk("rst.const", psr_to_id, 8'h34);
      resb = 1'b1;
      step("rel");

      // ALU commit, held request, drop
      psr_update_request = 1'b1;
      update_mask = 4'b1111;
      {n_result, v_result, z_result, c_result} = 4'b1001;
      step("alu1");
      chk("alu1.const", psr_to_id, 8'hB5);
      chk("alu1.ackc", {7'd0, ack_update_request}, 8'd1);
      {n_result, v_result, z_result, c_result} = 4'b0110;
      for (int k = 0; k < 3; k++) step("alu_hold");
      chk("alu_hold.const", psr_to_id, 8'hB5);
      psr_update_request = 1'b0;
      step("alu_drop");
      chk("alu_drop.ackc", {7'd0, ack_update_request}, 8'd0);

      // Async reset while in ACK
      psr_update_request = 1'b1;
      step("pre_arst");
      #1 resb = 1'b0;
      #1;
      mdl_reset();
      chk("arst.ack", {7'd0, ack_update_request}, 8'd0);
      chk("arst.psr", psr_to_id, 8'h34);
      psr_update_request = 1'b0;
      step("arst_hold");
      resb = 1'b1;
      step("arst_rel");

      // SEC, then masked Z commit colliding with CLC
      fop(3'd1);
      step("sec");
      clr_pulses();
      psr_update_request = 1'b1;
      update_mask = 4'b0010;
      {n_result, v_result, z_result, c_result} = 4'b0011;
      fop(3'd0);
      step("z_clc");
      clr_pulses();
      chk("z_clc.const", psr_to_id, 8'h36);
      psr_update_request = 1'b0;
      step("z_clc_drop");

      // PLP outranks ALU commit, ALU still acked
      psr_update_request = 1'b1;
      update_mask = 4'b1111;
      {n_result, v_result, z_result, c_result} = 4'b0000;
      plp_load = 1'b1;
      db_in = 8'hCF;
      step("plp_alu");
      clr_pulses();
      chk("plp_alu.const", psr_to_id, 8'hFF);
      chk("plp_alu.ackc", {7'd0, ack_update_request}, 8'd1);
      psr_update_request = 1'b0;
      step("plp_drop");

      // Interrupt entry with IRQ push image
      fop(3'd5);
      step("cld");
      fop(3'd6);
      step("sed");
      clr_pulses();
      int_entry = 1'b1;
      push_is_irq = 1'b1;
      #1;
      chk("irq.push_b", {7'd0, psr_push_out[4]}, 8'd0);
      chk("irq.push_d", {7'd0, psr_push_out[3]}, 8'd1);
      step("irq");
      clr_pulses();
      chk("irq.i", {7'd0, psr_to_id[2]}, 8'd1);
      chk("irq.d", {7'd0, d_decimal}, 8'd0);
      push_is_irq = 1'b0;

      // SO pin latency
      fop(3'd4);
      step("clv");
      clr_pulses();
      so_n = 1'b0;
      step("so1");
      chk("so1.v", {7'd0, psr_to_id[6]}, 8'd0);
      step("so2");
      chk("so2.v", {7'd0, psr_to_id[6]}, 8'd0);
      step("so3");
      chk("so3.v", {7'd0, psr_to_id[6]}, 8'd1);
      so_n = 1'b1;
      for (int k = 0; k < 4; k++) step("so_hi");
      // SO fall coinciding with CLV
      so_n = 1'b0;
      step("soc1");
      step("soc2");
      fop(3'd4);
      step("soc3");
      clr_pulses();
      chk("so_clv.v", {7'd0, psr_to_id[6]}, 8'd1);
      // Held low does not set again
      fop(3'd4);
      step("so_low_clv");
      clr_pulses();
      step("so_low");
      chk("so_low.v", {7'd0, psr_to_id[6]}, 8'd0);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         resb = ($urandom % 64) != 0;
         psr_update_request = 1'($urandom % 2);
         {n_result, v_result, z_result, c_result} = 4'($urandom);
         update_mask = 4'($urandom);
         flag_op_valid = ($urandom % 3) == 0;
         flag_op = 3'($urandom);
         plp_load = ($urandom % 8) == 0;
         db_in = 8'($urandom);
         int_entry = ($urandom % 10) == 0;
         if (($urandom % 6) == 0) so_n = ~so_n;
         push_is_irq = 1'($urandom % 2);
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/psr_unit.md
Name: psr_unit

Overview:
Processor status register stage directly downstream of the ALU. It consumes the ALU's n/v/z/c results through the psr_update_request / ack_update_request handshake. It applies decoder flag ops (CLC/SEC/CLI/SEI/CLV/CLD/SED), PLP loads, interrupt-entry side effects and the SO pin. It drives the architectural status byte back to the decoder and ALU (psr_to_id, c_carry, d_decimal) and the push image for PHP/BRK/IRQ.

Parameters:
SO_SYNC_STAGES, 2, flops in the so_n synchronizer (min 2)
RESET_PSR, 8'h34, psr_to_id value while in/after reset (bit5=1, B=1, I=1)

Ports:
fclk  in  1  system clock; all state on rising edge
resb  in  1  reset, asynchronous, active-low
psr_update_request  in  1  ALU result valid; level, held until ack seen
ack_update_request  out  1  commit acknowledge to ALU
n_result  in  1  ALU N result
v_result  in  1  ALU V result
z_result  in  1  ALU Z result
c_result  in  1  ALU C result
update_mask  in  4  {N,V,Z,C} write enables for ALU commit, sampled with request
flag_op_valid  in  1  one-cycle pulse: apply flag_op
flag_op  in  3  0 CLC, 1 SEC, 2 CLI, 3 SEI, 4 CLV, 5 CLD, 6 SED, 7 no-op
plp_load  in  1  one-cycle pulse: load status from db_in
db_in  in  8  pulled status byte
int_entry  in  1  one-cycle pulse: BRK/IRQ/NMI vectoring
so_n  in  1  set-overflow pin, async, falling edge active
push_is_irq  in  1  push image B bit = 0 when 1 (IRQ/NMI), 1 otherwise
psr_to_id  out  8  {N,V,1,1,D,I,Z,C}
psr_push_out  out  8  {N,V,1,~push_is_irq,D,I,Z,C}, combinational
c_carry  out  1  stored C
d_decimal  out  1  stored D

Behaviour:
- Reset (resb low, async): N=V=Z=C=0, D=0, I=1; psr_to_id=8'h34; ack_update_request=0; handshake FSM=IDLE; SO synchronizer flops=1 (inactive). Release mid-handshake returns to IDLE; the ALU request is re-sampled fresh.
- Storage: six flops N,V,D,I,Z,C. Bits 5 and 4 are not stored and always read 1 on psr_to_id.
- Handshake FSM, states IDLE, ACK:
  - IDLE & request=1: commit masked n/v/z/c this edge, go to ACK.
  - ACK: ack=1 (registered). Stay while request=1; no further commit. request=0 -> IDLE, ack=0 next cycle.
  - One commit per request assertion. Minimum request-to-ack latency is 1 cycle. Back-to-back requests need one IDLE cycle between them.
- Write priority per flag, per edge, highest first:
  1. int_entry: I<=1, D<=0; other flags untouched.
  2. plp_load: all six from db_in[7,6,3,2,1,0]; db_in[5:4] ignored.
  3. ALU commit: masked bits only.
  4. flag_op.
  - A lower-priority source still writes flags that no higher source touches in that edge. Example: ALU commit of C plus SEI in the same edge applies both.
- SO: so_n passes through SO_SYNC_STAGES flops. A synchronized 1->0 transition sets V=1 and overrides every other V write that edge. Holding so_n low does not re-set V. Latency from the pin edge to V is SO_SYNC_STAGES+1 edges.
- c_carry and d_decimal mirror the stored flops, so updates are visible the cycle after the write edge.
- psr_push_out reflects the current stored flags plus push_is_irq, with no register delay.
- flag_op=7 and any op while resb is low: ignored.

Test Plan:
- Reset: pulse resb low for 3 cycles -> psr_to_id=8'h34, c_carry=0, d_decimal=0, ack=0. Assert resb low mid-ACK -> ack drops immediately (async).
- ALU handshake: request=1, mask=4'b1111, n/v/z/c=1,0,0,1 -> next cycle psr_to_id=8'hB5, ack=1. Hold request 3 cycles -> single commit, ack held. Drop request -> ack=0 one cycle later.
- Masked commit plus collision: SEC first (C=1). Then request with mask=4'b0010, z=1 in the same edge as flag_op=CLC -> Z=1 and C=0, both applied.
- PLP vs ALU: plp_load with db_in=8'hCF in the same edge as an ALU commit with mask=4'b1111, all results 0 -> psr_to_id=8'hFF. The ALU is still acked but its write is lost.
- Interrupt: D=1 via SED, then int_entry with push_is_irq=1 -> psr_push_out bit4=0 and bit3=1 before the edge; after the edge I=1, D=0.
- SO pin: V=0, drive so_n 1->0 -> V=1 exactly 3 edges later. Same edge as CLV -> V=1. Hold so_n low, then CLV -> V stays 0.
